// File: rtl/moving_average_pkg.sv
// Shared sizing helpers for the moving_average block and its history buffer.
package moving_average_pkg;

  // Window length in samples for a given log2 length.
  function automatic int unsigned ma_len(input int unsigned log2_len);
    return 32'd1 << log2_len;
  endfunction

  // Running-sum width: wide enough for LEN full-scale samples.
  function automatic int unsigned ma_sum_w(input int unsigned n, input int unsigned log2_len);
    return n + log2_len;
  endfunction

  // Next write pointer, wrapping modulo the window length.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned log2_len);
    return (ptr + 32'd1) & (ma_len(log2_len) - 32'd1);
  endfunction

endpackage

// File: rtl/moving_average_if.sv
// Sample-in / average-out bus for moving_average.
interface moving_average_if #(
  parameter int unsigned N        = 5,
  parameter int unsigned LOG2_LEN = 2
);
  logic                    ce;
  logic                    clr;
  logic [N-1:0]            idata;
  logic [N+LOG2_LEN-1:0]   osum;
  logic [N-1:0]            odata;
  logic                    ovalid;
  logic                    ofull;

  modport master (
    output ce, clr, idata,
    input  osum, odata, ovalid, ofull
  );

  modport slave (
    input  ce, clr, idata,
    output osum, odata, ovalid, ofull
  );
endinterface

// File: rtl/moving_average_history.sv
// Circular LEN x N sample history; presents the entry about to be overwritten.
module ma_history
  import moving_average_pkg::*;
#(
  parameter int unsigned N        = 5,
  parameter int unsigned LOG2_LEN = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we_i,
  input  logic         clr_i,
  input  logic [N-1:0] wdata_i,
  output logic [N-1:0] old_o
);
  localparam int unsigned LEN = ma_len(LOG2_LEN);

  logic [N-1:0]          hist_q [LEN];
  logic [LOG2_LEN-1:0]   wptr_q;
  logic [LOG2_LEN-1:0]   wptr_d;

  // Read-before-write: old_o is the entry the current write will replace.
  assign old_o = hist_q[wptr_q];

  // Pointer advance with natural wrap.
  always_comb begin
    wptr_d = LOG2_LEN'(ptr_next(32'(wptr_q), LOG2_LEN));
  end

  // History entries and write pointer; clear wins over write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LEN; i++) hist_q[i] <= '0;
      wptr_q <= '0;
    end else if (clr_i) begin
      for (int unsigned i = 0; i < LEN; i++) hist_q[i] <= '0;
      wptr_q <= '0;
    end else if (we_i) begin
      hist_q[wptr_q] <= wdata_i;
      wptr_q         <= wptr_d;
    end
  end

endmodule

// File: rtl/moving_average.sv
// Boxcar moving average: running sum of the last LEN samples and its floor average.
module moving_average
  import moving_average_pkg::*;
#(
  parameter int unsigned N        = 5,
  parameter int unsigned LOG2_LEN = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  moving_average_if.slave    bus
);
  localparam int unsigned     LEN      = ma_len(LOG2_LEN);
  localparam int unsigned     SUM_W    = ma_sum_w(N, LOG2_LEN);
  localparam logic [LOG2_LEN:0] FILL_MAX = (LOG2_LEN+1)'(LEN);
  localparam logic [LOG2_LEN:0] FILL_ONE = (LOG2_LEN+1)'(1);

  logic               accept;
  logic [N-1:0]       old;
  logic [SUM_W-1:0]   sum_q,   sum_d;
  logic [N-1:0]       odata_q, odata_d;
  logic [LOG2_LEN:0]  fill_q,  fill_d;
  logic               ofull_q, ofull_d;
  logic               ovalid_q;

  assign accept = bus.ce & ~bus.clr;

  ma_history #(
    .N        (N),
    .LOG2_LEN (LOG2_LEN)
  ) u_hist (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (accept),
    .clr_i   (bus.clr),
    .wdata_i (bus.idata),
    .old_o   (old)
  );

  // Next sum adds the new sample and drops the evicted one; the difference
  // never goes negative because old is already part of sum_q.
  always_comb begin
    sum_d   = sum_q + SUM_W'(bus.idata) - SUM_W'(old);
    odata_d = sum_d[SUM_W-1:LOG2_LEN];
    fill_d  = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_ONE;
    ofull_d = ofull_q | (fill_d == FILL_MAX);
  end

  // Sum, fill count and output registers; clr has priority over ce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q    <= '0;
      odata_q  <= '0;
      fill_q   <= '0;
      ofull_q  <= 1'b0;
      ovalid_q <= 1'b0;
    end else if (bus.clr) begin
      sum_q    <= '0;
      odata_q  <= '0;
      fill_q   <= '0;
      ofull_q  <= 1'b0;
      ovalid_q <= 1'b0;
    end else if (bus.ce) begin
      sum_q    <= sum_d;
      odata_q  <= odata_d;
      fill_q   <= fill_d;
      ofull_q  <= ofull_d;
      ovalid_q <= 1'b1;
    end else begin
      ovalid_q <= 1'b0;
    end
  end

  assign bus.osum   = sum_q;
  assign bus.odata  = odata_q;
  assign bus.ovalid = ovalid_q;
  assign bus.ofull  = ofull_q;

endmodule

// File: doc/moving_average.md
Name: moving_average

Overview:
- Boxcar moving-average stage downstream of the ce-gated sample delay line.
- Consumes one N-bit unsigned sample per ce strobe and keeps a circular history of the last 2^LOG2_LEN samples.
- Maintains a running sum and outputs the sum and the floor-average, registered, with a valid pulse.
- Output feeds the next ce-gated processing stage; ovalid serves as that stage's ce.

Parameters:
- N, 5, sample width in bits (unsigned); N >= 1.
- LOG2_LEN, 2, log2 of window length; LEN = 2^LOG2_LEN samples; LOG2_LEN >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset; assertion clears all state immediately; deassertion is synchronous to clk.
- ce  input  1  sample strobe; idata accepted on a rising clk edge when ce=1.
- clr  input  1  synchronous clear of history, sum, fill count and pointer.
- idata  input  N  unsigned input sample.
- osum  output  N+LOG2_LEN  running sum of the last LEN accepted samples (registered).
- odata  output  N  floor(osum / LEN), i.e. osum >> LOG2_LEN (registered).
- ovalid  output  1  one-cycle pulse, high the cycle after each accepted sample.
- ofull  output  1  high once LEN samples have been accepted since the last reset or clr.

Behaviour:
- Reset (rst_n=0): history entries = 0, sum = 0, wptr = 0, fill count = 0, osum = 0, odata = 0, ovalid = 0, ofull = 0.
- Accept on edge with ce=1, clr=0:
  - old = hist[wptr]; hist[wptr] <= idata; sum <= sum + idata - old; wptr <= wptr+1 mod LEN (natural wrap, LOG2_LEN bits).
  - fill count increments, saturating at LEN.
- Latency is 1 cycle: osum, odata and ovalid are updated on the same edge that accepts the sample. odata is computed from the new sum.
- ce=0, clr=0: all state and osum/odata/ofull hold; ovalid = 0.
- Arithmetic: sum width is N+LOG2_LEN, so there is no overflow (max LEN*(2^N-1)). The subtraction never underflows because old is contained in sum. odata truncates (floor), no rounding.
- Start-up: history is zero-filled, so before ofull the average includes zeros. No masking is applied; downstream uses ofull to qualify.
- ofull is set on the edge that accepts the LEN-th sample and is sticky until clr or reset.
- clr=1: history, sum, wptr, fill count, osum, odata, ofull are cleared to 0 and ovalid = 0. If ce=1 in the same cycle, clr wins and the sample is discarded.
- Reset mid-operation: immediate asynchronous clear as above. The first accepted sample after release goes to hist[0].
- Back-to-back ce on every cycle is supported at full rate, with no bubbles.
- The history read and write of the same entry in one cycle is read-before-write (old value is used).

Decomposition:
- Shared package/header: LEN = 1<<LOG2_LEN, SUM_W = N+LOG2_LEN, and a width-safe pointer-increment function.
- Sub-module ma_history: LEN x N circular buffer with async-reset entries, write pointer, and combinational read of the entry at wptr. It returns old and owns wptr wrap.
- Top level holds the sum, fill counter, clr priority and output registers.

Test Plan (N=5, LOG2_LEN=2):
1. Assert rst_n=0 mid-cycle with garbage on inputs -> osum=0, odata=0, ovalid=0, ofull=0 immediately, without waiting for a clk edge.
2. After reset, ce=1 for 4 consecutive cycles with idata=8 -> osum 8,16,24,32; odata 2,4,6,8; ovalid high on each of those 4 cycles; ofull rises with the 4th.
3. Continue with idata=0,0,0,0 (wrap-around) -> osum 24,16,8,0; odata 6,4,2,0; ofull stays 1.
4. Feed 31 four times -> osum 124, odata 31, with no overflow. Then feed 1 -> osum 94, odata 23.
5. Sequence 3,(ce=0 x3),5 -> ovalid pulses only after accepted samples; osum holds 3 during gap, then 8; odata 0 then 2.
6. With ofull=1, pulse clr=1 together with ce=1, idata=20 -> osum=0, odata=0, ofull=0, ovalid=0 (sample dropped). Next sample 12 -> osum 12, odata 3, written to hist[0].
